clken_gen: RTL and testbench

CLKEN_GEN -- requirements
Module: clken_gen

---
 rtl/clken_pkg.sv | 11 +
 rtl/clken_acc.sv | 33 +++
 rtl/clken_gen.sv | 108 ++++++++++
 tb/tb_clken_gen.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clken_pkg.sv
// Shared types and constants for the clock-enable generator.
package clken_pkg;

  localparam int CH_W = 4;

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/clken_acc.sv
// Single-channel phase accumulator; ce is the registered carry-out of acc + inc.
module clken_acc #(
  parameter int ACC_W = 32
) (
  input  logic             refclk,
  input  logic             run,
  input  logic             clear,
  input  logic [ACC_W-1:0] inc,
  output logic             ce
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ce_q, ce_d;

  // clear wins over run so a reset or realign never leaks a partial pulse
  always_comb begin
    acc_d = acc_q;
    ce_d  = 1'b0;
    if (clear) begin
      acc_d = '0;
    end else if (run) begin
      {ce_d, acc_d} = {1'b0, acc_q} + {1'b0, inc};
    end
  end

  always_ff @(posedge refclk) begin
    acc_q <= acc_d;
    ce_q  <= ce_d;
  end

  assign ce = ce_q;

endmodule

// File: rtl/clken_gen.sv
// Multi-channel fractional clock-enable generator with settle/lock sequencing
// and a valid/ready configuration port for per-channel increments.
module clken_gen
  import clken_pkg::*;
#(
  parameter int                      NUM_CH      = 3,
  parameter int                      ACC_W       = 32,
  parameter int                      LOCK_CYCLES = 1024,
  parameter logic [NUM_CH*ACC_W-1:0] INIT_INC    = '0
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] ce,
  output logic              locked
);

  localparam int              CNT_W   = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(LOCK_CYCLES - 1);

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          locked_q, locked_d;
  logic                          err_q, err_d;
  logic [NUM_CH-1:0][ACC_W-1:0]  inc_q, inc_d;

  logic xfer, chOk, goodXfer, clearAcc;

  // locked lags the LOCKED state by one cycle, which gives the accumulators
  // one idle cycle at zero before the first add (cycle 0 of the phase grid)
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    locked_d = 1'b0;
    err_d    = 1'b0;
    inc_d    = inc_q;
    goodXfer = 1'b0;
    xfer     = cfg_valid & locked_q;
    chOk     = 32'(cfg_ch) < 32'(NUM_CH);

    unique case (state_q)
      SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = LOCKED;
          cnt_d   = '0;
        end
      end
      LOCKED: begin
        locked_d = 1'b1;
        if (xfer && chOk) begin
          goodXfer = 1'b1;
          for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) inc_d[i] = cfg_inc;
          end
          state_d  = SETTLE;
          cnt_d    = '0;
          locked_d = 1'b0;
        end else if (xfer) begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = SETTLE;
        cnt_d   = '0;
      end
    endcase

    clearAcc = !rst_n || (state_q == SETTLE) || goodXfer;
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q  <= SETTLE;
      cnt_q    <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      inc_q    <= INIT_INC;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      inc_q    <= inc_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : gChan
    clken_acc #(
      .ACC_W(ACC_W)
    ) uAcc (
      .refclk(refclk),
      .run   (locked_q),
      .clear (clearAcc),
      .inc   (inc_q[g]),
      .ce    (ce[g])
    );
  end

  assign locked    = locked_q;
  assign cfg_ready = locked_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_clken_gen.sv
// Randomized bench for clken_gen against a cycle-age reference model.
module tb_clken_gen;

  localparam int NUM_CH      = 3;
  localparam int ACC_W       = 8;
  localparam int LOCK_CYCLES = 16;
  localparam int LOCK_AGE    = LOCK_CYCLES + 1;
  localparam logic [NUM_CH*ACC_W-1:0] INIT_INC = {8'd64, 8'd128, 8'd0};

  logic              refclk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_valid = 1'b0;
  logic [3:0]        cfg_ch = '0;
  logic [ACC_W-1:0]  cfg_inc = '0;
  logic              cfg_ready, cfg_err, locked;
  logic [NUM_CH-1:0] ce;

  int nVec = 0;
  int nMis = 0;

  // model: age = cycles since the last reset or accepted write
  int age = 0;
  int mInc[NUM_CH] = '{0, 128, 64};
  int initTab[NUM_CH] = '{0, 128, 64};
  bit mErr = 1'b0;

  always #5 refclk = ~refclk;

  clken_gen #(
    .NUM_CH     (NUM_CH),
    .ACC_W      (ACC_W),
    .LOCK_CYCLES(LOCK_CYCLES),
    .INIT_INC   (INIT_INC)
  ) dut (
    .refclk   (refclk),
    .rst_n    (rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_inc  (cfg_inc),
    .cfg_err  (cfg_err),
    .ce       (ce),
    .locked   (locked)
  );

  always @(posedge refclk) begin
    if (!rst_n) begin
      age  <= 0;
      mErr <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) mInc[i] <= initTab[i];
    end else begin
      mErr <= 1'b0;
      age  <= age + 1;
      if (age >= LOCK_AGE && cfg_valid) begin
        if (int'(cfg_ch) < NUM_CH) begin
          mInc[cfg_ch] <= int'(cfg_inc);
          age <= 0;
        end else begin
          mErr <= 1'b1;
        end
      end
    end
  end

  // expected {locked, cfg_ready, cfg_err, ce} from the pulse-count formula
  function automatic logic [5:0] expVec();
    logic [2:0] e;
    bit lk;
    longint k;
    e  = '0;
    lk = (age >= LOCK_AGE);
    k  = longint'(age - LOCK_AGE);
    if (lk && k >= 1) begin
      for (int i = 0; i < NUM_CH; i++)
        e[i] = ((k * mInc[i]) / 256) > (((k - 1) * mInc[i]) / 256);
    end
    return {lk, lk, mErr, e};
  endfunction

  task automatic test_reset();
    logic [5:0] got, want;
    got = '0;
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge refclk);
      got = {locked, cfg_ready, cfg_err, ce};
      want = expVec();
      nVec++;
      if (got !== want) begin
        nMis++;
        $display("[TB] FAIL reset c%0d: got %b want %b", c, got, want);
      end
    end
    nVec++;
    if (got !== 6'b0) begin
      nMis++;
      $display("[TB] FAIL reset_zero: got %b want 000000", got);
    end
  endtask

  task automatic test_lock_timing();
    logic [5:0] got, want;
    int firstLock;
    firstLock = -1;
    rst_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge refclk);
      got = {locked, cfg_ready, cfg_err, ce};
      want = expVec();
      nVec++;
      if (got !== want) begin
        nMis++;
        $display("[TB] FAIL lock_timing c%0d: got %b want %b", c, got, want);
      end
      if (locked === 1'b1 && firstLock < 0) firstLock = c;
    end
    nVec++;
    if (firstLock != 17) begin
      nMis++;
      $display("[TB] FAIL lock_cycle: got %0d want 17", firstLock);
    end
  endtask

  task automatic test_rate_phase();
    logic [5:0] got, want;
    int cnt0, cnt1, cnt2;
    cnt0 = 0; cnt1 = 0; cnt2 = 0;
    for (int c = 0; c < 128; c++) begin
      @(negedge refclk);
      got = {locked, cfg_ready, cfg_err, ce};
      want = expVec();
      nVec++;
      if (got !== want) begin
        nMis++;
        $display("[TB] FAIL rate_phase c%0d: got %b want %b", c, got, want);
      end
      cnt0 += int'(ce[0]);
      cnt1 += int'(ce[1]);
      cnt2 += int'(ce[2]);
    end
    nVec++;
    if (cnt0 != 0 || cnt1 != 64 || cnt2 != 32) begin
      nMis++;
      $display("[TB] FAIL pulse_counts: got %0d/%0d/%0d want 0/64/32", cnt0, cnt1, cnt2);
    end
  endtask

  task automatic test_bad_channel();
    logic [5:0] got, want;
    int errCnt, lockDrop;
    errCnt = 0; lockDrop = 0;
    cfg_valid = 1'b1;
    cfg_ch = 4'd5;
    cfg_inc = 8'($urandom_range(1, 255));
    for (int c = 0; c < 6; c++) begin
      @(negedge refclk);
      got = {locked, cfg_ready, cfg_err, ce};
      want = expVec();
      nVec++;
      if (got !== want) begin
        nMis++;
        $display("[TB] FAIL bad_channel c%0d: got %b want %b", c, got, want);
      end
      cfg_valid = 1'b0;
      errCnt += int'(cfg_err);
      if (locked !== 1'b1) lockDrop++;
    end
    nVec++;
    if (errCnt != 1 || lockDrop != 0) begin
      nMis++;
      $display("[TB] FAIL bad_channel_err: got err=%0d drops=%0d want err=1 drops=0", errCnt, lockDrop);
    end
  endtask

  task automatic test_reprogram();
    logic [5:0] got, want;
    int rise;
    int ks[$];
    int expK[6] = '{4, 7, 10, 13, 16, 19};
    rise = -1;
    cfg_valid = 1'b1;
    cfg_ch = 4'd0;
    cfg_inc = 8'd85;
    for (int c = 0; c < 40; c++) begin
      @(negedge refclk);
      got = {locked, cfg_ready, cfg_err, ce};
      want = expVec();
      nVec++;
      if (got !== want) begin
        nMis++;
        $display("[TB] FAIL reprogram c%0d: got %b want %b", c, got, want);
      end
      cfg_valid = 1'b0;
      if (locked === 1'b1 && rise < 0) rise = c;
      if (rise >= 0 && ce[0] === 1'b1) ks.push_back(c - rise);
    end
    nVec++;
    if (rise != LOCK_AGE) begin
      nMis++;
      $display("[TB] FAIL reprogram_relock: got %0d want %0d", rise, LOCK_AGE);
    end
    for (int i = 0; i < 6; i++) begin
      nVec++;
      if (ks.size() <= i || ks[i] != expK[i]) begin
        nMis++;
        $display("[TB] FAIL reprogram_k%0d: got %0d want %0d", i, (ks.size() > i) ? ks[i] : -1, expK[i]);
      end
    end
  endtask

  task automatic test_write_during_settle();
    logic [5:0] got, want;
    int firstLock;
    bit held, dropSeen;
    firstLock = -1; held = 1'b0; dropSeen = 1'b0;
    cfg_valid = 1'b1;
    cfg_ch = 4'd1;
    cfg_inc = 8'($urandom_range(1, 255));
    for (int c = 0; c < 60; c++) begin
      @(negedge refclk);
      got = {locked, cfg_ready, cfg_err, ce};
      want = expVec();
      nVec++;
      if (got !== want) begin
        nMis++;
        $display("[TB] FAIL settle_write c%0d: got %b want %b", c, got, want);
      end
      if (locked === 1'b1 && firstLock < 0 && c > 0) firstLock = c;
      if (c == 18 && locked === 1'b0) dropSeen = 1'b1;
      if (held) cfg_valid = 1'b0;
      if (c == 0) begin
        cfg_ch = 4'd2;
        cfg_inc = 8'($urandom_range(1, 255));
      end
      if (c > 0 && age >= LOCK_AGE && !held) held = 1'b1;
    end
    cfg_valid = 1'b0;
    nVec++;
    if (firstLock != 17 || !dropSeen) begin
      nMis++;
      $display("[TB] FAIL settle_xfer: got lock=%0d drop=%0d want lock=17 drop=1", firstLock, dropSeen);
    end
  endtask

  task automatic test_max_inc();
    logic [5:0] got, want;
    int rise;
    logic k1, k2;
    rise = -1; k1 = 1'bx; k2 = 1'bx;
    cfg_valid = 1'b1;
    cfg_ch = 4'd0;
    cfg_inc = 8'd255;
    for (int c = 0; c < 30; c++) begin
      @(negedge refclk);
      got = {locked, cfg_ready, cfg_err, ce};
      want = expVec();
      nVec++;
      if (got !== want) begin
        nMis++;
        $display("[TB] FAIL max_inc c%0d: got %b want %b", c, got, want);
      end
      cfg_valid = 1'b0;
      if (locked === 1'b1 && rise < 0) rise = c;
      if (rise >= 0 && c == rise + 1) k1 = ce[0];
      if (rise >= 0 && c == rise + 2) k2 = ce[0];
    end
    nVec++;
    if (k1 !== 1'b0 || k2 !== 1'b1) begin
      nMis++;
      $display("[TB] FAIL max_inc_k1k2: got %b%b want 01", k1, k2);
    end
  endtask

  task automatic test_mid_reset();
    logic [5:0] got, want;
    int firstLock, ch1Cnt;
    firstLock = -1; ch1Cnt = 0;
    repeat ($urandom_range(1, 20)) @(negedge refclk);
    rst_n = 1'b0;
    @(negedge refclk);
    got = {locked, cfg_ready, cfg_err, ce};
    nVec++;
    if (got !== 6'b0) begin
      nMis++;
      $display("[TB] FAIL mid_reset_zero: got %b want 000000", got);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 27; c++) begin
      @(negedge refclk);
      got = {locked, cfg_ready, cfg_err, ce};
      want = expVec();
      nVec++;
      if (got !== want) begin
        nMis++;
        $display("[TB] FAIL mid_reset c%0d: got %b want %b", c, got, want);
      end
      if (locked === 1'b1 && firstLock < 0) firstLock = c;
      if (c > 17 && c <= 25) ch1Cnt += int'(ce[1]);
    end
    nVec++;
    if (firstLock != LOCK_AGE || ch1Cnt != 4) begin
      nMis++;
      $display("[TB] FAIL mid_reset_relock: got lock=%0d ch1=%0d want lock=%0d ch1=4", firstLock, ch1Cnt, LOCK_AGE);
    end
  endtask

  task automatic test_random();
    logic [5:0] got, want;
    for (int c = 0; c < 800; c++) begin
      @(negedge refclk);
      got = {locked, cfg_ready, cfg_err, ce};
      want = expVec();
      nVec++;
      if (got !== want) begin
        nMis++;
        $display("[TB] FAIL random c%0d: got %b want %b", c, got, want);
      end
      rst_n = ($urandom_range(0, 199) != 0);
      cfg_valid = ($urandom_range(0, 24) == 0);
      cfg_ch = 4'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: cfg_inc = 8'd0;
        1: cfg_inc = 8'd255;
        default: cfg_inc = 8'($urandom_range(1, 254));
      endcase
    end
    rst_n = 1'b1;
    cfg_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lock_timing();
    test_rate_phase();
    test_bad_channel();
    test_reprogram();
    test_write_during_settle();
    test_max_inc();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
